toy_dmem_responder: RTL

- Data-memory responder for the RISC_TOY core. It sits on the far end of the core's DREQ/DRW/DADDR/DWDATA/DRDATA port.
- Word-addressed synchronous SRAM model with a registered read path.
- Adds a testbench/boot loader backdoor write port, sticky error reporting and optional access counters.
- Used in the system top and in the core-level bench in place of a behavioural memory.

---
 rtl/toy_mem_pkg.sv | 15 +
 rtl/toy_sram_1rw.sv | 31 +++
 rtl/toy_dmem_responder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/toy_mem_pkg.sv
// Shared constants and FSM encoding for the RISC_TOY data-memory responder.
package toy_mem_pkg;

   localparam int unsigned DADDR_W = 30;
   localparam int unsigned DATA_W  = 32;

   localparam logic DRW_RD = 1'b0;
   localparam logic DRW_WR = 1'b1;

   typedef enum logic [0:0] {
      StClear,
      StIdle
   } dmem_state_e;

endpackage

// File: rtl/toy_sram_1rw.sv
// Single-port DEPTH x DATA_W synchronous SRAM with registered read and write enable.
module toy_sram_1rw
   import toy_mem_pkg::*;
#(
   parameter int unsigned AW = 10
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/toy_dmem_responder.sv
// Data-memory responder: SRAM model with loader backdoor, reset-clear sweep and sticky errors.
// Optional access counters are enabled by defining DMEM_ACCESS_CNT_EN.
module toy_dmem_responder
   import toy_mem_pkg::*;
#(
   parameter int unsigned AW        = 10,
   parameter bit          INIT_ZERO = 1'b1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               DREQ,
   input  logic               DRW,
   input  logic [DADDR_W-1:0] DADDR,
   input  logic [DATA_W-1:0]  DWDATA,
   output logic [DATA_W-1:0]  DRDATA,
   input  logic               LD_EN,
   input  logic [AW-1:0]      LD_ADDR,
   input  logic [DATA_W-1:0]  LD_DATA,
   output logic               BUSY,
   output logic               ERR_OOR,
   output logic               ERR_COL,
   output logic [DADDR_W-1:0] ERR_ADDR,
   output logic [31:0]        RD_CNT,
   output logic [31:0]        WR_CNT
);

   dmem_state_e state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;

   logic active, sweep, in_range, col, oor, core_rd, core_wr, drop_rd;
   logic sram_we, sram_re;
   logic [AW-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata, sram_rdata;
   logic zero_q, err_oor_q, err_col_q;
   logic [DADDR_W-1:0] err_addr_q;

   assign active   = (state_q == StIdle) && !RST;
   assign sweep    = (state_q == StClear) && !RST;
   assign in_range = (DADDR >> AW) == '0;
   assign col      = active && DREQ && LD_EN;
   assign oor      = active && DREQ && !in_range;
   assign core_rd  = active && DREQ && !LD_EN && in_range && (DRW == DRW_RD);
   assign core_wr  = active && DREQ && !LD_EN && in_range && (DRW == DRW_WR);
   assign drop_rd  = active && DREQ && (DRW == DRW_RD) && (LD_EN || !in_range);

   // Single port: sweep beats loader, loader beats the core.
   always_comb begin
      sram_we    = 1'b0;
      sram_re    = 1'b0;
      sram_addr  = DADDR[AW-1:0];
      sram_wdata = DWDATA;
      if (sweep) begin
         sram_we    = 1'b1;
         sram_addr  = idx_q;
         sram_wdata = '0;
      end else if (active && LD_EN) begin
         sram_we    = 1'b1;
         sram_addr  = LD_ADDR;
         sram_wdata = LD_DATA;
      end else if (core_wr) begin
         sram_we = 1'b1;
      end else if (core_rd) begin
         sram_re = 1'b1;
      end
   end

   toy_sram_1rw #(
      .AW(AW)
   ) u_sram (
      .clk_i  (CLK),
      .we_i   (sram_we),
      .re_i   (sram_re),
      .addr_i (sram_addr),
      .wdata_i(sram_wdata),
      .rdata_o(sram_rdata)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (state_q == StClear) begin
         idx_d = idx_q + 1'b1;
         if (idx_q == '1) begin
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= INIT_ZERO ? StClear : StIdle;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // zero_q masks the SRAM output so dropped reads and reset present 0 without a wide register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         zero_q     <= 1'b1;
         err_oor_q  <= 1'b0;
         err_col_q  <= 1'b0;
         err_addr_q <= '0;
      end else begin
         if (drop_rd) begin
            zero_q <= 1'b1;
         end else if (core_rd) begin
            zero_q <= 1'b0;
         end
         if (oor) begin
            err_oor_q <= 1'b1;
            if (!err_oor_q) begin
               err_addr_q <= DADDR;
            end
         end
         if (col) begin
            err_col_q <= 1'b1;
         end
      end
   end

`ifdef DMEM_ACCESS_CNT_EN
   logic [31:0] rd_cnt_q, wr_cnt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         if (core_rd && (rd_cnt_q != '1)) begin
            rd_cnt_q <= rd_cnt_q + 32'd1;
         end
         if (core_wr && (wr_cnt_q != '1)) begin
            wr_cnt_q <= wr_cnt_q + 32'd1;
         end
      end
   end

   assign RD_CNT = rd_cnt_q;
   assign WR_CNT = wr_cnt_q;
`else
   assign RD_CNT = '0;
   assign WR_CNT = '0;
`endif

   assign DRDATA   = zero_q ? '0 : sram_rdata;
   assign BUSY     = (state_q == StClear);
   assign ERR_OOR  = err_oor_q;
   assign ERR_COL  = err_col_q;
   assign ERR_ADDR = err_addr_q;

endmodule
